// File: rtl/layer1_pkg.sv
// Shared layer-1 definitions: lane geometry, sequencer state encoding and an
// address-width helper used by the sequencer, the MAC array and downstream blocks.
package layer1_pkg;

  localparam int unsigned LANES        = 10;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned COL_W        = LANES * DATA_W;
  localparam int unsigned DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    WAIT
  } state_e;

  // Address/index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer1_sequencer.sv
// Layer-1 sequencer: walks every output neuron through clear / issue / drain and
// hands each accumulator column downstream through a one-entry valid/ready slot.
module layer1_sequencer
  import layer1_pkg::*;
#(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_OUT = 16,
  parameter int unsigned WA_W  = addr_w(N_IN * N_OUT),
  parameter int unsigned PA_W  = addr_w(N_IN),
  parameter int unsigned IDX_W = addr_w(N_OUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              px_rd_en,
  output logic [PA_W-1:0]   px_addr,
  input  logic [COL_W-1:0]  px_rdata,
  output logic              mac_clr_n,
  output logic [DATA_W-1:0] weight,
  output logic [COL_W-1:0]  pixels,
  input  logic [COL_W-1:0]  column,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [COL_W-1:0]  res_data,
  output logic [IDX_W-1:0]  res_idx
);

  localparam int unsigned        DRAIN_W    = 2;
  localparam logic [PA_W-1:0]    LAST_K     = PA_W'(N_IN - 1);
  localparam logic [IDX_W-1:0]   LAST_J     = IDX_W'(N_OUT - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    j_q, j_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_en_dly_q, rd_en_dly_d;
  logic [WA_W-1:0]     w_addr_q, w_addr_d;
  logic [PA_W-1:0]     px_addr_q, px_addr_d;
  logic                mac_clr_n_q, mac_clr_n_d;
  logic [DATA_W-1:0]   weight_q, weight_d;
  logic [COL_W-1:0]    pixels_q, pixels_d;
  logic                res_valid_q, res_valid_d;
  logic [COL_W-1:0]    res_data_q, res_data_d;
  logic [IDX_W-1:0]    res_idx_q, res_idx_d;

  logic hs_c;
  logic slot_free_c;
  logic capture_c;

  assign hs_c        = res_valid_q & res_ready;
  assign slot_free_c = ~res_valid_q | res_ready;

  // Next-state, counters, result slot and data stage.
  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    w_addr_d    = w_addr_q;
    px_addr_d   = px_addr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    capture_c   = 1'b0;

    if (hs_c) begin
      res_valid_d = 1'b0;
    end
    // The final column of a run leaving the slot ends the run.
    if (hs_c && busy_q && (state_q == IDLE) && (res_idx_q == LAST_J)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          state_d   = CLEAR;
          busy_d    = 1'b1;
          j_d       = '0;
          w_addr_d  = '0;
          px_addr_d = '0;
        end
      end
      CLEAR: state_d = ISSUE;
      ISSUE: begin
        // Weight address runs across neurons, so neuron j starts at j*N_IN.
        w_addr_d = w_addr_q + WA_W'(1);
        if (px_addr_q == LAST_K) begin
          px_addr_d = '0;
          drain_d   = '0;
          state_d   = DRAIN;
        end else begin
          px_addr_d = px_addr_q + PA_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          if (slot_free_c) begin
            capture_c = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      WAIT:    capture_c = slot_free_c;
      default: state_d = IDLE;
    endcase

    if (capture_c) begin
      res_valid_d = 1'b1;
      res_data_d  = column;
      res_idx_d   = j_q;
      if (j_q == LAST_J) begin
        state_d = IDLE;
      end else begin
        j_d     = j_q + IDX_W'(1);
        state_d = CLEAR;
      end
    end

    rd_en_d     = (state_d == ISSUE);
    rd_en_dly_d = rd_en_q;
    mac_clr_n_d = (state_d != CLEAR);
    weight_d    = rd_en_dly_q ? w_rdata : '0;
    pixels_d    = rd_en_dly_q ? px_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      j_q         <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_en_dly_q <= 1'b0;
      w_addr_q    <= '0;
      px_addr_q   <= '0;
      mac_clr_n_q <= 1'b0;
      weight_q    <= '0;
      pixels_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_en_dly_q <= rd_en_dly_d;
      w_addr_q    <= w_addr_d;
      px_addr_q   <= px_addr_d;
      mac_clr_n_q <= mac_clr_n_d;
      weight_q    <= weight_d;
      pixels_q    <= pixels_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_rd_en   = rd_en_q;
  assign px_rd_en  = rd_en_q;
  assign w_addr    = w_addr_q;
  assign px_addr   = px_addr_q;
  assign mac_clr_n = mac_clr_n_q;
  assign weight    = weight_q;
  assign pixels    = pixels_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;

endmodule

// File: tb/tb_layer1_sequencer.sv
// Bench for layer1_sequencer: three configurations share RAM contents and a MAC-array
// model; a scoreboard queue holds expected columns popped by per-instance monitors.
module tb_layer1_sequencer;
  import layer1_pkg::*;

  localparam int unsigned NI0 = 4, NO0 = 2;
  localparam int unsigned NI1 = 1, NO1 = 1;
  localparam int unsigned NI2 = 3, NO2 = 4;
  localparam int unsigned WA0 = addr_w(NI0 * NO0), PA0 = addr_w(NI0), IX0 = addr_w(NO0);
  localparam int unsigned WA1 = addr_w(NI1 * NO1), PA1 = addr_w(NI1), IX1 = addr_w(NO1);
  localparam int unsigned WA2 = addr_w(NI2 * NO2), PA2 = addr_w(NI2), IX2 = addr_w(NO2);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] w_mem  [0:31];
  logic [COL_W-1:0]  px_mem [0:7];

  logic [2:0] start_v = '0;
  logic [2:0] ready_v = '1;
  logic [2:0] rst_v   = '0;

  typedef struct {
    int              inst;
    int              idx;
    logic [COL_W-1:0] col;
  } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic busy0, done0, ren0, pren0, clr0, valid0;
  logic busy1, done1, ren1, pren1, clr1, valid1;
  logic busy2, done2, ren2, pren2, clr2, valid2;
  logic [WA0-1:0] wa0; logic [PA0-1:0] pa0; logic [IX0-1:0] idx0;
  logic [WA1-1:0] wa1; logic [PA1-1:0] pa1; logic [IX1-1:0] idx1;
  logic [WA2-1:0] wa2; logic [PA2-1:0] pa2; logic [IX2-1:0] idx2;
  logic [DATA_W-1:0] wd0 = '0, wd1 = '0, wd2 = '0, wt0, wt1, wt2;
  logic [COL_W-1:0]  pd0 = '0, pd1 = '0, pd2 = '0, px0, px1, px2;
  logic [COL_W-1:0]  col0 = '0, col1 = '0, col2 = '0, rd0, rd1, rd2;
  wire  [2:0] busy_v  = {busy2, busy1, busy0};
  wire  [2:0] valid_v = {valid2, valid1, valid0};

  layer1_sequencer #(.N_IN(NI0), .N_OUT(NO0)) u_dut0 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .busy(busy0), .done(done0),
    .w_rd_en(ren0), .w_addr(wa0), .w_rdata(wd0), .px_rd_en(pren0), .px_addr(pa0),
    .px_rdata(pd0), .mac_clr_n(clr0), .weight(wt0), .pixels(px0), .column(col0),
    .res_valid(valid0), .res_ready(ready_v[0]), .res_data(rd0), .res_idx(idx0));
  layer1_sequencer #(.N_IN(NI1), .N_OUT(NO1)) u_dut1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .busy(busy1), .done(done1),
    .w_rd_en(ren1), .w_addr(wa1), .w_rdata(wd1), .px_rd_en(pren1), .px_addr(pa1),
    .px_rdata(pd1), .mac_clr_n(clr1), .weight(wt1), .pixels(px1), .column(col1),
    .res_valid(valid1), .res_ready(ready_v[1]), .res_data(rd1), .res_idx(idx1));
  layer1_sequencer #(.N_IN(NI2), .N_OUT(NO2)) u_dut2 (
    .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .busy(busy2), .done(done2),
    .w_rd_en(ren2), .w_addr(wa2), .w_rdata(wd2), .px_rd_en(pren2), .px_addr(pa2),
    .px_rdata(pd2), .mac_clr_n(clr2), .weight(wt2), .pixels(px2), .column(col2),
    .res_valid(valid2), .res_ready(ready_v[2]), .res_data(rd2), .res_idx(idx2));

  // External MAC array: 10 independent 16-bit accumulators with synchronous clear.
  function automatic logic [COL_W-1:0] mac_step(input logic [COL_W-1:0] acc, input logic clr_n,
                                                input logic [DATA_W-1:0] w, input logic [COL_W-1:0] p);
    logic [COL_W-1:0] r;
    r = '0;
    if (clr_n) begin
      for (int l = 0; l < int'(LANES); l++)
        r[l*DATA_W +: DATA_W] = acc[l*DATA_W +: DATA_W] + DATA_W'(w * p[l*DATA_W +: DATA_W]);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (ren0) wd0 <= w_mem[int'(wa0)];
    if (pren0) pd0 <= px_mem[int'(pa0)];
    col0 <= mac_step(col0, clr0, wt0, px0);
    if (ren1) wd1 <= w_mem[int'(wa1)];
    if (pren1) pd1 <= px_mem[int'(pa1)];
    col1 <= mac_step(col1, clr1, wt1, px1);
    if (ren2) wd2 <= w_mem[int'(wa2)];
    if (pren2) pd2 <= px_mem[int'(pa2)];
    col2 <= mac_step(col2, clr2, wt2, px2);
  end

  // Reference: neuron j lane L = sum over k of w[j*N_IN+k] * pixel[k][L], modulo 2^16.
  function automatic logic [COL_W-1:0] ref_col(input int j, input int ni);
    logic [COL_W-1:0] r;
    int unsigned s;
    r = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      s = 0;
      for (int k = 0; k < ni; k++)
        s += int'(w_mem[j*ni + k]) * int'(px_mem[k][l*DATA_W +: DATA_W]);
      r[l*DATA_W +: DATA_W] = DATA_W'(s);
    end
    return r;
  endfunction

  task automatic chk_int(input string name, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0d expected %0d", name, inst, act, exp);
    end
  endtask

  task automatic chk_col(input string name, input int inst, input logic [COL_W-1:0] act,
                         input logic [COL_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
    end
  endtask

  bit               exp_done   [3];
  bit               prev_stall [3];
  logic [COL_W-1:0] prev_data  [3];
  int               prev_idx   [3];

  task automatic mon(input int inst, input int no, input logic v, input logic r, input int idx,
                     input logic [COL_W-1:0] d, input logic dn, input logic bs);
    exp_t e;
    if (exp_done[inst] || dn) begin
      chk_int("done_pulse", inst, int'(dn), int'(exp_done[inst]));
      if (exp_done[inst]) chk_int("busy_after_last", inst, int'(bs), 0);
      exp_done[inst] = 1'b0;
    end
    if (prev_stall[inst] && v) begin
      chk_col("res_data_stable", inst, d, prev_data[inst]);
      chk_int("res_idx_stable", inst, idx, prev_idx[inst]);
    end
    if (v && r) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result inst%0d: got idx %0d expected none", inst, idx);
      end else begin
        e = exp_q.pop_front();
        chk_int("res_idx", inst, inst*16 + idx, e.inst*16 + e.idx);
        chk_col("res_data", inst, d, e.col);
        if (e.idx == no - 1) exp_done[inst] = 1'b1;
      end
    end
    prev_stall[inst] = v && !r;
    prev_data[inst]  = d;
    prev_idx[inst]   = idx;
  endtask

  always @(negedge clk) mon(0, NO0, valid0, ready_v[0], int'(idx0), rd0, done0, busy0);
  always @(negedge clk) mon(1, NO1, valid1, ready_v[1], int'(idx1), rd1, done1, busy1);
  always @(negedge clk) mon(2, NO2, valid2, ready_v[2], int'(idx2), rd2, done2, busy2);

  function automatic int get_idx(input int inst);
    case (inst)
      0:       return int'(idx0);
      1:       return int'(idx1);
      default: return int'(idx2);
    endcase
  endfunction

  task automatic push_run(input int inst, input int ni, input int no);
    exp_t e;
    for (int j = 0; j < no; j++) begin
      e.inst = inst; e.idx = j; e.col = ref_col(j, ni);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int inst, output int unsigned t0);
    @(posedge clk); #1 start_v[inst] = 1'b1;
    @(posedge clk); #1 start_v[inst] = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_valid(input int inst, input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid_v[inst] && get_idx(inst) == idx) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_valid inst%0d: got no result idx %0d expected within %0d cycles", inst, idx, budget);
    end
  endtask

  task automatic wait_idle(input int inst, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_v[inst]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_idle inst%0d: got busy expected idle within %0d cycles", inst, budget);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) w_mem[i] = DATA_W'(i + 1);
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < int'(LANES); l++) px_mem[k][l*DATA_W +: DATA_W] = DATA_W'(l + k);
  endtask

  task automatic load_random(input int nw, input int np);
    for (int i = 0; i < nw; i++) w_mem[i] = DATA_W'($urandom);
    for (int k = 0; k < np; k++) px_mem[k] = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    bit ok;
    logic [COL_W-1:0] snap;
    for (int i = 0; i < 32; i++) w_mem[i] = '0;
    for (int i = 0; i < 8; i++) px_mem[i] = '0;
    snap = '0;

    // Reset values while reset is held low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("rst_busy_done", 0, int'({busy0, done0, ren0, pren0, valid0}), 0);
    chk_int("rst_addr", 0, int'(wa0) + int'(pa0) + int'(idx0), 0);
    chk_int("rst_mac_clr_n", 0, int'(clr0), 0);
    chk_col("rst_pixels", 0, px0 | COL_W'(wt0), '0);
    chk_col("rst_res_data", 0, rd0, '0);
    @(posedge clk); #1 rst_v = '1;

    // Ramp data, ready held high.
    load_ramp();
    push_run(0, NI0, NO0);
    pulse_start(0, t0);
    wait_valid(0, 0, 40, ok);
    if (ok) chk_int("n0_lane0", 0, int'(rd0[DATA_W-1:0]), 20);
    wait_valid(0, 1, 40, ok);
    if (ok) chk_int("run_latency", 0, int'(cyc - t0), int'(NO0 * (NI0 + 4)));
    wait_idle(0, 40);

    // Downstream stall after the first capture.
    ready_v[0] = 1'b0;
    push_run(0, NI0, NO0);
    pulse_start(0, t0);
    wait_valid(0, 0, 40, ok);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 12) snap = col0;
    end
    chk_col("array_hold", 0, col0, snap);
    chk_col("array_sum_n1", 0, col0, ref_col(1, NI0));
    chk_int("stall_idx", 0, get_idx(0), 0);
    @(posedge clk); #1 ready_v[0] = 1'b1;
    wait_idle(0, 40);

    // Second start mid-run is ignored.
    push_run(0, NI0, NO0);
    pulse_start(0, t0);
    repeat (4) @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    wait_valid(0, 1, 40, ok);
    if (ok) chk_int("restart_latency", 0, int'(cyc - t0), int'(NO0 * (NI0 + 4)));
    wait_idle(0, 40);
    repeat (6) @(negedge clk);
    chk_int("no_restart", 0, int'(busy0), 0);
    chk_int("queue_empty_a", 0, exp_q.size(), 0);

    // Reset during issue of neuron 1.
    push_run(0, NI0, NO0);
    pulse_start(0, t0);
    wait_valid(0, 0, 40, ok);
    @(posedge clk); @(posedge clk); #1 rst_v[0] = 1'b0;
    @(posedge clk); #1;
    chk_int("abort_busy_valid", 0, int'({busy0, valid0, ren0}), 0);
    chk_int("abort_weight", 0, int'(wt0), 0);
    chk_int("abort_pending", 0, exp_q.size(), 1);
    exp_q.delete();
    rst_v[0] = 1'b1;
    push_run(0, NI0, NO0);
    pulse_start(0, t0);
    wait_idle(0, 60);
    chk_int("queue_empty_b", 0, exp_q.size(), 0);

    // Single input, single neuron.
    w_mem[0] = 16'd3;
    for (int l = 0; l < int'(LANES); l++) px_mem[0][l*DATA_W +: DATA_W] = 16'd5;
    push_run(1, NI1, NO1);
    pulse_start(1, t0);
    wait_valid(1, 0, 20, ok);
    if (ok) begin
      chk_int("single_latency", 1, int'(cyc - t0), int'(NO1 * (NI1 + 4)));
      chk_col("single_col", 1, rd1, {10{16'd15}});
    end
    wait_idle(1, 20);

    // Ready toggling every cycle across four neurons.
    load_random(NI2 * NO2, NI2);
    push_run(2, NI2, NO2);
    pulse_start(2, t0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy_v[2]) break;
      ready_v[2] = ~ready_v[2];
    end
    ready_v[2] = 1'b1;
    wait_idle(2, 20);
    chk_int("queue_empty_c", 2, exp_q.size(), 0);

    // Random data, random ready, spurious starts while busy.
    for (int r = 0; r < 4; r++) begin
      load_random(NI2 * NO2, NI2);
      push_run(2, NI2, NO2);
      pulse_start(2, t0);
      for (int i = 0; i < 500; i++) begin
        @(posedge clk); #1;
        if (!busy_v[2]) break;
        ready_v[2] = 1'($urandom_range(0, 1));
        start_v[2] = ($urandom_range(0, 5) == 0);
      end
      start_v[2] = 1'b0;
      ready_v[2] = 1'b1;
      wait_idle(2, 20);
      chk_int("queue_empty_r", 2, exp_q.size(), 0);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
